spongent_req_arbiter: RTL and testbench

//  Shares one spongent hash core among NUM_REQ requesters. Round-robin arbitration,

---
 rtl/spongent_req_arbiter.sv | 122 ++++++++++++
 tb/tb_spongent_req_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spongent_req_arbiter.sv
// rtl/spongent_req_arbiter.sv - round-robin arbiter sharing one spongent hash core
// Grants one requester per run, sequences core restart, waits for end_hash or watchdog.
module spongent_req_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int N          = 256,
  parameter int NUM_REQ    = 2,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 4096
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_msg,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            core_rst,
  output logic [DATA_WIDTH-1:0]           core_msg,
  input  logic                            core_end,
  input  logic [N-1:0]                    core_hash,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]      rsp_id,
  output logic [N-1:0]                    rsp_hash,
  output logic                            rsp_err,
  output logic                            busy
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam int RC_W  = $clog2(RST_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RST_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CORE_RST, RUN, RESP} state_t;

  state_t            state;
  logic [ID_W-1:0]   last;
  logic [ID_W-1:0]   gid;
  logic [ID_W-1:0]   pick;
  logic [ID_W-1:0]   cand;
  logic [RC_W-1:0]   rc;
  logic [CNT_W-1:0]  run_cnt;

  // Walk offsets from farthest to nearest so the requester right after 'last' wins.
  always_comb begin
    pick = '0;
    cand = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = ID_W'((int'(last) + k) % NUM_REQ);
      if (req_valid[cand]) pick = cand;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      last      <= ID_W'(NUM_REQ - 1);
      gid       <= '0;
      rc        <= '0;
      run_cnt   <= '0;
      req_ready <= '0;
      core_rst  <= 1'b1;
      core_msg  <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_hash  <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      req_ready <= '0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            req_ready <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
            core_msg  <= req_msg[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
            gid       <= pick;
            rc        <= '0;
            busy      <= 1'b1;
            state     <= CORE_RST;
          end
        end
        CORE_RST: begin
          if (rc == RC_LAST) begin
            core_rst <= 1'b0;
            run_cnt  <= '0;
            state    <= RUN;
          end else begin
            rc <= rc + 1'b1;
          end
        end
        RUN: begin
          // A core_end seen on the first RUN cycle is left over from the previous run.
          if (core_end && run_cnt != '0) begin
            rsp_hash  <= core_hash;
            rsp_err   <= 1'b0;
            rsp_id    <= gid;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (run_cnt == CNT_LAST) begin
            rsp_hash  <= '0;
            rsp_err   <= 1'b1;
            rsp_id    <= gid;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            last      <= gid;
            core_rst  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spongent_req_arbiter.sv
// tb/tb_spongent_req_arbiter.sv - directed bench for spongent_req_arbiter
// Two instances: default watchdog, and a short watchdog for the abort scenario.
module tb_spongent_req_arbiter;

  localparam logic [63:0]  MSG0 = 64'h0123456789ABCDEF;
  localparam logic [63:0]  MSG1 = 64'hFEDCBA9876543210;
  localparam logic [255:0] H1   = {4{64'hDEADBEEF01234567}};
  localparam logic [255:0] H2   = {4{64'h0F1E2D3C4B5A6978}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int checks = 0;
  int errors = 0;

  logic [127:0] req_msg;
  assign req_msg = {MSG1, MSG0};

  logic [1:0]   req_valid, req_ready;
  logic         core_rst, core_end, rsp_valid, rsp_ready, rsp_err, busy;
  logic [63:0]  core_msg;
  logic [255:0] core_hash, rsp_hash;
  logic [0:0]   rsp_id;

  logic [1:0]   req_valid2, req_ready2;
  logic         core_rst2, core_end2, rsp_valid2, rsp_ready2, rsp_err2, busy2;
  logic [63:0]  core_msg2;
  logic [255:0] core_hash2, rsp_hash2;
  logic [0:0]   rsp_id2;

  // Core models: cycle count since restart released; end at a set count.
  logic [15:0] cnt1, cnt2;
  int          lat1;
  logic        stuck1, end_en2;
  always @(posedge clk) cnt1 <= core_rst ? 16'd0 : cnt1 + 16'd1;
  always @(posedge clk) cnt2 <= core_rst2 ? 16'd0 : cnt2 + 16'd1;
  assign core_end   = stuck1 | (cnt1 == 16'(lat1));
  assign core_hash  = H1 + {240'd0, cnt1};
  assign core_end2  = end_en2 & (cnt2 == 16'd10);
  assign core_hash2 = H2 + {240'd0, cnt2};

  spongent_req_arbiter #(.DATA_WIDTH(64), .N(256), .NUM_REQ(2), .RST_CYCLES(2), .TIMEOUT(4096)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_msg(req_msg), .req_ready(req_ready),
    .core_rst(core_rst), .core_msg(core_msg), .core_end(core_end), .core_hash(core_hash),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_hash(rsp_hash),
    .rsp_err(rsp_err), .busy(busy)
  );

  spongent_req_arbiter #(.DATA_WIDTH(64), .N(256), .NUM_REQ(2), .RST_CYCLES(2), .TIMEOUT(64)) dut_to (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_msg(req_msg), .req_ready(req_ready2),
    .core_rst(core_rst2), .core_msg(core_msg2), .core_end(core_end2), .core_hash(core_hash2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_id(rsp_id2), .rsp_hash(rsp_hash2),
    .rsp_err(rsp_err2), .busy(busy2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = '0; rsp_ready = 1'b0; req_valid2 = '0; rsp_ready2 = 1'b0;
    stuck1 = 1'b0; lat1 = 140; end_en2 = 1'b0;
    repeat (3) step();
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL reset_core_rst: got %b expected 1", core_rst); end
    checks++; if (core_msg !== 64'd0) begin errors++; $display("FAIL reset_core_msg: got %h expected 0", core_msg); end
    checks++; if ({rsp_valid, rsp_id, rsp_err, busy} !== 4'b0000) begin errors++; $display("FAIL reset_rsp_flags: got %b expected 0000", {rsp_valid, rsp_id, rsp_err, busy}); end
    checks++; if (rsp_hash !== 256'd0) begin errors++; $display("FAIL reset_rsp_hash: got %h expected 0", rsp_hash); end
    checks++; if ({rsp_valid2, core_rst2, busy2} !== 3'b010) begin errors++; $display("FAIL reset_dut_to: got %b expected 010", {rsp_valid2, core_rst2, busy2}); end
    rst = 1'b1;
    step(); step();
    checks++; if ({req_ready, busy, core_rst} !== 4'b0001) begin errors++; $display("FAIL reset_idle_after_release: got %b expected 0001", {req_ready, busy, core_rst}); end
  endtask

  task automatic test_single();
    int n, k, hi, pulses;
    lat1 = 140;
    req_valid = 2'b01;
    n = 0;
    do begin step(); n++; end while (req_ready == 2'b00 && n < 20);
    checks++; if (n != 1 || req_ready !== 2'b01) begin errors++; $display("FAIL t1_grant: got req_ready=%b after %0d cyc expected 01 after 1", req_ready, n); end
    checks++; if (core_msg !== MSG0) begin errors++; $display("FAIL t1_core_msg: got %h expected %h", core_msg, MSG0); end
    req_valid = 2'b00;
    hi = core_rst ? 1 : 0;
    pulses = 0;
    for (k = 1; k <= 300; k++) begin
      step();
      if (req_ready != 2'b00) pulses++;
      if (core_rst) hi++;
      if (rsp_valid) break;
    end
    checks++; if (k != 143) begin errors++; $display("FAIL t1_latency: got %0d expected 143", k); end
    checks++; if (hi != 2) begin errors++; $display("FAIL t1_core_rst_len: got %0d expected 2", hi); end
    checks++; if (pulses != 0) begin errors++; $display("FAIL t1_extra_ready: got %0d expected 0", pulses); end
    checks++; if ({rsp_id, rsp_err, busy} !== 3'b001) begin errors++; $display("FAIL t1_rsp_flags: got %b expected 001", {rsp_id, rsp_err, busy}); end
    checks++; if (rsp_hash !== H1 + 256'd140) begin errors++; $display("FAIL t1_rsp_hash: got %h expected %h", rsp_hash, H1 + 256'd140); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++; if ({rsp_valid, busy, core_rst} !== 3'b001) begin errors++; $display("FAIL t1_handshake: got %b expected 001", {rsp_valid, busy, core_rst}); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_rdy [4];
    int n;
    exp_rdy = '{2'b01, 2'b10, 2'b01, 2'b10};
    rst = 1'b0; step(); rst = 1'b1; step();
    lat1 = 5; rsp_ready = 1'b1; req_valid = 2'b11;
    for (int r = 0; r < 4; r++) begin
      n = 0;
      do begin step(); n++; end while (req_ready == 2'b00 && n < 20);
      checks++; if (req_ready !== exp_rdy[r]) begin errors++; $display("FAIL t2_grant%0d: got %b expected %b", r, req_ready, exp_rdy[r]); end
      checks++; if (core_msg !== (exp_rdy[r] == 2'b01 ? MSG0 : MSG1)) begin errors++; $display("FAIL t2_msg%0d: got %h", r, core_msg); end
      n = 0;
      do begin step(); n++; end while (!rsp_valid && n < 50);
      if (r == 3) req_valid = 2'b00;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'(r % 2)) begin errors++; $display("FAIL t2_rsp_id%0d: got valid=%b id=%0d expected valid=1 id=%0d", r, rsp_valid, rsp_id, r % 2); end
    end
    step();
    rsp_ready = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t2_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_backpressure();
    int n;
    rsp_ready = 1'b0; lat1 = 5; req_valid = 2'b01;
    n = 0;
    do begin step(); n++; end while (req_ready == 2'b00 && n < 20);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL t3_grant: got %b expected 01", req_ready); end
    n = 0;
    do begin step(); n++; end while (!rsp_valid && n < 50);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({rsp_valid, rsp_id, rsp_err, req_ready, busy} !== 6'b100001 || rsp_hash !== H1 + 256'd5) begin
        errors++;
        $display("FAIL t3_hold%0d: got v/id/err/rdy/busy=%b hash=%h expected 100001 hash=%h", i, {rsp_valid, rsp_id, rsp_err, req_ready, busy}, rsp_hash, H1 + 256'd5);
      end
      step();
    end
    req_valid = 2'b00; rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL t3_release: got rsp_valid=%b expected 0", rsp_valid); end
    step();
    checks++; if ({req_ready, busy} !== 3'b000) begin errors++; $display("FAIL t3_no_regrant: got %b expected 000", {req_ready, busy}); end
  endtask

  task automatic test_reset_mid_run();
    int n;
    lat1 = 140; rsp_ready = 1'b0; req_valid = 2'b10;
    n = 0;
    do begin step(); n++; end while (req_ready == 2'b00 && n < 20);
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL t6_first_grant: got %b expected 10", req_ready); end
    repeat (5) step();
    checks++; if ({core_rst, busy} !== 2'b01) begin errors++; $display("FAIL t6_in_run: got rst/busy=%b expected 01", {core_rst, busy}); end
    rst = 1'b0;
    #1;
    checks++;
    if ({req_ready, core_rst, rsp_valid, rsp_id, rsp_err, busy} !== 7'b0010000 || core_msg !== 64'd0 || rsp_hash !== 256'd0) begin
      errors++;
      $display("FAIL t6_async_reset: got flags=%b msg=%h hash=%h expected 0010000 0 0", {req_ready, core_rst, rsp_valid, rsp_id, rsp_err, busy}, core_msg, rsp_hash);
    end
    step(); step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL t6_no_rsp: got %b expected 0", rsp_valid); end
    lat1 = 5; rsp_ready = 1'b1; req_valid = 2'b11;
    rst = 1'b1;
    for (int r = 0; r < 2; r++) begin
      n = 0;
      do begin step(); n++; end while (req_ready == 2'b00 && n < 20);
      checks++; if (req_ready !== (r == 0 ? 2'b01 : 2'b10)) begin errors++; $display("FAIL t6_regrant%0d: got %b expected %b", r, req_ready, (r == 0 ? 2'b01 : 2'b10)); end
      n = 0;
      do begin step(); n++; end while (!rsp_valid && n < 50);
      if (r == 1) req_valid = 2'b00;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'(r)) begin errors++; $display("FAIL t6_rsp%0d: got valid=%b id=%0d expected valid=1 id=%0d", r, rsp_valid, rsp_id, r); end
    end
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_stale_end();
    int n, k;
    stuck1 = 1'b1; lat1 = 140; rsp_ready = 1'b0; req_valid = 2'b01;
    n = 0;
    do begin step(); n++; end while (req_ready == 2'b00 && n < 20);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL t5_grant: got %b expected 01", req_ready); end
    req_valid = 2'b00;
    for (k = 1; k <= 50; k++) begin
      step();
      if (rsp_valid) break;
    end
    checks++; if (k != 4) begin errors++; $display("FAIL t5_latency: got %0d expected 4", k); end
    checks++; if (rsp_hash !== H1 + 256'd1 || rsp_err !== 1'b0) begin errors++; $display("FAIL t5_hash: got %h err=%b expected %h err=0", rsp_hash, rsp_err, H1 + 256'd1); end
    stuck1 = 1'b0; rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int n, k, run_at;
    end_en2 = 1'b0; rsp_ready2 = 1'b0; req_valid2 = 2'b01;
    n = 0;
    do begin step(); n++; end while (req_ready2 == 2'b00 && n < 20);
    checks++; if (req_ready2 !== 2'b01) begin errors++; $display("FAIL t4_grant: got %b expected 01", req_ready2); end
    req_valid2 = 2'b00;
    run_at = -1;
    for (k = 1; k <= 200; k++) begin
      step();
      if (!core_rst2 && run_at < 0) run_at = k;
      if (rsp_valid2) break;
    end
    checks++; if (run_at != 2 || k - run_at != 64) begin errors++; $display("FAIL t4_timeout_latency: got run_at=%0d rsp_at=%0d expected 2 and 66", run_at, k); end
    checks++; if ({rsp_err2, rsp_id2} !== 2'b10 || rsp_hash2 !== 256'd0) begin errors++; $display("FAIL t4_abort_rsp: got err/id=%b hash=%h expected 10 hash=0", {rsp_err2, rsp_id2}, rsp_hash2); end
    rsp_ready2 = 1'b1;
    step();
    rsp_ready2 = 1'b0;
    end_en2 = 1'b1; req_valid2 = 2'b10;
    n = 0;
    do begin step(); n++; end while (req_ready2 == 2'b00 && n < 20);
    checks++; if (req_ready2 !== 2'b10) begin errors++; $display("FAIL t4_next_grant: got %b expected 10", req_ready2); end
    req_valid2 = 2'b00;
    for (k = 1; k <= 200; k++) begin
      step();
      if (rsp_valid2) break;
    end
    checks++; if (k != 13) begin errors++; $display("FAIL t4_next_latency: got %0d expected 13", k); end
    checks++; if ({rsp_err2, rsp_id2} !== 2'b01 || rsp_hash2 !== H2 + 256'd10) begin errors++; $display("FAIL t4_next_rsp: got err/id=%b hash=%h expected 01 hash=%h", {rsp_err2, rsp_id2}, rsp_hash2, H2 + 256'd10); end
    rsp_ready2 = 1'b1;
    step();
    rsp_ready2 = 1'b0;
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL t4_idle: got busy=%b expected 0", busy2); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_mid_run();
    test_stale_end();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
